// File: rtl/pedestrian_signal_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pedestrian_signal_controller_pkg
// Brief   : Shared state encoding and vehicle light timing for the crossing.
// Revision: 1.0 - initial release
// ============================================================================
package pedestrian_signal_controller_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GUARD = 2'd1,
        ST_WALK  = 2'd2,
        ST_FLASH = 2'd3
    } ped_state_t;

    // Vehicle phase lengths in controller clock cycles.
    localparam int c_GREEN_CYCLES  = 15;
    localparam int c_YELLOW_CYCLES = 1;
    localparam int c_RED_CYCLES    = 17;

    localparam int c_TIMER_W = 5;

endpackage : pedestrian_signal_controller_pkg
`default_nettype wire

// File: rtl/pedestrian_signal_controller_phase_timer.sv
`default_nettype none
// ============================================================================
// Module  : phase_timer
// Brief   : Loadable down-counter that saturates at zero; done while at zero.
// Revision: 1.0 - initial release
// ============================================================================
module phase_timer
    import pedestrian_signal_controller_pkg::*;
#(
    parameter int W = c_TIMER_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign done = (r_count == '0);

endmodule : phase_timer
`default_nettype wire

// File: rtl/pedestrian_signal_controller.sv
`default_nettype none
// ============================================================================
// Module  : pedestrian_signal_controller
// Brief   : Pedestrian WALK/DON'T WALK sequencer slaved to the vehicle lights.
// Revision: 1.0 - initial release
// ============================================================================
module pedestrian_signal_controller
    import pedestrian_signal_controller_pkg::*;
#(
    parameter int WALK_T  = 10,
    parameter int FLASH_T = 5,
    parameter int GUARD_T = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       green,
    input  logic       yellow,
    input  logic       red,
    input  logic       ped_btn,
    output logic       walk,
    output logic       dont_walk,
    output logic       wait_lamp,
    output logic [4:0] countdown,
    output logic       fault
);

    localparam logic [c_TIMER_W-1:0] c_GUARD_LOAD = c_TIMER_W'(GUARD_T - 1);
    localparam logic [c_TIMER_W-1:0] c_WALK_LOAD  = c_TIMER_W'(WALK_T - 1);
    localparam logic [c_TIMER_W-1:0] c_FLASH_LOAD = c_TIMER_W'(FLASH_T - 1);
    localparam logic [4:0]           c_CROSS_T    = 5'(WALK_T + FLASH_T);

    generate
        if (GUARD_T < 1 || WALK_T < 1 || FLASH_T < 1 ||
            (GUARD_T + WALK_T + FLASH_T) > c_RED_CYCLES) begin : g_bad_timing
            $error("pedestrian_signal_controller: crossing does not fit in vehicle red");
        end
    endgenerate

    ped_state_t           r_state;
    ped_state_t           w_next_state;
    logic                 r_red_q;
    logic                 r_req_pending;
    logic                 w_red_rise;
    logic                 w_bad_lights;
    logic                 w_enter_walk;
    logic                 w_timer_load;
    logic [c_TIMER_W-1:0] w_timer_val;
    logic                 w_timer_done;
    logic                 w_walk_nxt;
    logic                 w_dont_walk_nxt;
    logic [4:0]           w_countdown_nxt;
    logic                 w_req_nxt;

    assign w_red_rise   = red & ~r_red_q;
    assign w_bad_lights = ({2'b00, green} + {2'b00, yellow} + {2'b00, red}) != 3'd1;
    assign w_enter_walk = (w_next_state == ST_WALK) && (r_state != ST_WALK);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_red_rise && (r_req_pending || ped_btn)) w_next_state = ST_GUARD;
            end
            ST_GUARD: begin
                if (!red)              w_next_state = ST_IDLE;
                else if (w_timer_done) w_next_state = ST_WALK;
            end
            ST_WALK: begin
                if (!red)              w_next_state = ST_IDLE;
                else if (w_timer_done) w_next_state = ST_FLASH;
            end
            ST_FLASH: begin
                if (!red || w_timer_done) w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
        // Inconsistent vehicle lights, now or ever since reset, pin us to IDLE.
        if (w_bad_lights || fault) w_next_state = ST_IDLE;
    end

    always_comb begin
        w_timer_load    = (w_next_state != r_state);
        w_timer_val     = '0;
        w_walk_nxt      = 1'b0;
        w_dont_walk_nxt = 1'b1;
        w_countdown_nxt = 5'd0;
        w_req_nxt       = r_req_pending;
        case (w_next_state)
            ST_GUARD: w_timer_val = c_GUARD_LOAD;
            ST_WALK:  w_timer_val = c_WALK_LOAD;
            ST_FLASH: w_timer_val = c_FLASH_LOAD;
            default:  w_timer_val = '0;
        endcase
        if (w_next_state == ST_WALK) begin
            w_walk_nxt      = 1'b1;
            w_dont_walk_nxt = 1'b0;
        end else if (w_next_state == ST_FLASH && r_state == ST_FLASH) begin
            w_dont_walk_nxt = ~dont_walk;
        end
        if (w_enter_walk) begin
            w_countdown_nxt = c_CROSS_T;
        end else if (w_next_state == ST_WALK || w_next_state == ST_FLASH) begin
            w_countdown_nxt = countdown - 5'd1;
        end
        if (w_enter_walk) begin
            w_req_nxt = 1'b0;
        end else if (ped_btn && r_state != ST_WALK) begin
            w_req_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_red_q       <= 1'b1;
            r_req_pending <= 1'b0;
            walk          <= 1'b0;
            dont_walk     <= 1'b1;
            countdown     <= 5'd0;
            fault         <= 1'b0;
        end else begin
            r_state       <= w_next_state;
            r_red_q       <= red;
            r_req_pending <= w_req_nxt;
            walk          <= w_walk_nxt;
            dont_walk     <= w_dont_walk_nxt;
            countdown     <= w_countdown_nxt;
            fault         <= fault | w_bad_lights;
        end
    end

    assign wait_lamp = r_req_pending;

    phase_timer #(
        .W (c_TIMER_W)
    ) u_phase_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (w_timer_load),
        .load_val (w_timer_val),
        .done     (w_timer_done)
    );

endmodule : pedestrian_signal_controller
`default_nettype wire
